mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store unit for the MEM stage. Takes one memory op per enabled cycle and issues a single bus transaction.
//  Aligns store data and byte strobes; sign/zero-extends load data. Flags misaligned accesses and bus timeouts as faults.
//  Sits between the pipeline controller (enabled/completed handshake) and the memory bus (request_enable/response_enable).
// PARAMETERS
//  DATA_W      32   bus/register width; 32 or 64. NB = DATA_W/8 byte lanes, LB = log2(NB)
//  ADDR_W      32   address width
//  TIMEOUT     1024 max cycles in WAIT before fault; 0 = never time out
// PORTS
//  clk              in   1        clock
//  rstn             in   1        asynchronous active-low reset
//  enabled          in   1        op valid; sampled only in IDLE
//  completed        out  1        one-cycle pulse: op finished, result/fault valid
//  op_load          in   1        load op
//  op_store         in   1        store op (op_load has priority if both are set)
//  op_size          in   2        0=byte 1=half 2=word 3=dword (dword legal only if DATA_W=64)
//  op_unsigned      in   1        zero-extend load (lbu/lhu/lwu)
//  op_addr          in   ADDR_W   byte address
//  op_wdata         in   DATA_W   store data, LSB-justified
//  result           out  DATA_W   extended load data; 0 for stores/no-op/fault
//  fault            out  1        valid with completed: 1 = op aborted
//  fault_cause      out  2        0=none 1=load-misaligned 2=store-misaligned 3=bus timeout
//  request_enable   out  1        one-cycle bus request pulse
//  mode             out  1        MEMREQ_READ / MEMREQ_WRITE (def.sv)
//  addr             out  ADDR_W   bus address, NB-aligned (low LB bits zero)
//  wdata            out  DATA_W   store data shifted to byte lane op_addr[LB-1:0]
//  wstrb            out  NB       byte-lane strobes; all zero for reads
//  response_enable  in   1        bus done; data valid on reads
//  data             in   DATA_W   bus read data, aligned word
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE. Every output 0; timeout counter 0.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE, enabled=1, cycle N:
//   - Latch op fields.
//   - Misaligned (op_addr % (1<<op_size) != 0, or size 3 with DATA_W=32):
//     go to RESP; no bus request; fault=1, cause 1 (load) or 2 (store).
//   - Load/store:
//     go to WAIT; request_enable=1 in cycle N+1 only; addr = op_addr with low LB bits cleared.
//     wstrb = ((1<<(1<<op_size))-1) << off, where off = op_addr[LB-1:0].
//     wdata = op_wdata << 8*off.
//   - Neither load nor store: go to RESP; result=0, fault=0.
//  WAIT: count cycles.
//   - response_enable=1: latch data, go to RESP.
//   - Count reaches TIMEOUT (TIMEOUT!=0): go to RESP with fault=1, cause 3.
//   - A response on the same cycle as the timeout wins: no fault.
//  RESP: completed=1 for exactly one cycle, with result/fault/fault_cause. Then IDLE.
//   - Load result: bytes (1<<op_size) of data starting at lane off.
//     Sign-extended from the top bit of the selected field unless op_unsigned, then zero-extended.
//   - result, fault and fault_cause hold until the next completed pulse.
//  Latency:
//   - fault/no-op: completed at N+1.
//   - bus op with response at cycle M >= N+1: completed at M+1. Minimum latency 2.
//  Ignored inputs:
//   - enabled outside IDLE.
//   - response_enable outside WAIT, including stale responses after reset or after a timeout.
//  Reset mid-WAIT: op is dropped and no completed pulse follows.
//  Only one outstanding bus transaction; the request is never reissued.
// TESTING
//  1 DATA_W=32: lb addr=0x103, bus data=0x80_00_00_00
//    -> request addr=0x100, wstrb=0, result=0xFFFFFF80, completed once.
//  2 DATA_W=32: sh addr=0x202, wdata=0x1234ABCD
//    -> addr=0x200, wstrb=4'b1100, wdata=0xABCD0000, mode=WRITE, result=0.
//  3 lhu addr=0x301 -> completed at N+1, fault=1, cause=1, request_enable never high.
//  4 TIMEOUT=8, lw with no response -> completed 9 cycles after request, fault=1, cause=3.
//    A response one cycle later is ignored.
//  5 DATA_W=64: lwu addr=0x...C, data=0xF0000001_00000000
//    -> addr low 3 bits 0, result=0x00000000_F0000001.
//  6 Deassert rstn during WAIT; then a new lw with response on the following cycle
//    -> all outputs 0 after reset, no completed from the dropped op, new op returns data.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline and memory-bus signals of the MEM-stage load/store unit.
// master = the load/store unit, slave = the pipeline controller plus memory model.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    // Handshakes carry no backpressure. enabled is taken only while the unit is idle,
    // and completed pulses for one cycle per accepted op. request_enable pulses once
    // per bus op, and the first response_enable seen while waiting ends that op.
    logic              enabled;
    logic              completed;
    logic              op_load;
    logic              op_store;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [DATA_W-1:0] result;
    logic              fault;
    logic [1:0]        fault_cause;

    logic              request_enable;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wstrb;
    logic              response_enable;
    logic [DATA_W-1:0] data;

    modport master (
        input  enabled, op_load, op_store, op_size, op_unsigned, op_addr, op_wdata,
        input  response_enable, data,
        output completed, result, fault, fault_cause,
        output request_enable, mode, addr, wdata, wstrb
    );

    modport slave (
        output enabled, op_load, op_store, op_size, op_unsigned, op_addr, op_wdata,
        output response_enable, data,
        input  completed, result, fault, fault_cause,
        input  request_enable, mode, addr, wdata, wstrb
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per op, with store lane alignment,
// load extension, and misalignment/timeout faults.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    mem_access_unit_if.master  bus,
    output logic [1:0]         dbg_state_o
);
    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int IW    = $clog2(DATA_W);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              load_q, load_d, uns_q, uns_d, req_q, req_d, mode_q, mode_d;
    logic              fault_q, fault_d;
    logic [1:0]        size_q, size_d, cause_q, cause_d;
    logic [LB-1:0]     off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, result_q, result_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;

    logic              is_load, is_store, misaligned, timeout_hit, sign;
    logic [LB-1:0]     off_in;
    logic [7:0]        lane8;
    logic [IW-1:0]     msb;
    logic [DATA_W-1:0] sh, ext;

    assign is_load     = bus.op_load;
    assign is_store    = bus.op_store & ~bus.op_load;
    assign off_in      = bus.op_addr[LB-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_C);

    always_comb begin
        misaligned = 1'b0;
        lane8      = 8'h01;
        case (bus.op_size)
            2'd0: begin misaligned = 1'b0;                                  lane8 = 8'h01; end
            2'd1: begin misaligned = bus.op_addr[0];                        lane8 = 8'h03; end
            2'd2: begin misaligned = |bus.op_addr[1:0];                     lane8 = 8'h0F; end
            default: begin misaligned = (DATA_W == 32) | (|bus.op_addr[2:0]); lane8 = 8'hFF; end
        endcase
    end

    // Load extension: select the field at the latched lane, then extend from its top bit.
    always_comb begin
        sh  = bus.data >> {off_q, 3'b000};
        ext = '0;
        case (size_q)
            2'd0:    msb = IW'(7);
            2'd1:    msb = IW'(15);
            2'd2:    msb = IW'(31);
            default: msb = IW'(DATA_W - 1);
        endcase
        sign = sh[msb] & ~uns_q;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i <= int'(msb)) ? sh[i] : sign;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.enabled) begin
                if (!(is_load | is_store) || misaligned) state_d = RESP;
                else                                      state_d = WAIT;
            end
            WAIT:    if (bus.response_enable || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_d = load_q; uns_d = uns_q; size_d = size_q; off_d = off_q;
        req_d = 1'b0; mode_d = mode_q; addr_d = addr_q; wdata_d = wdata_q; wstrb_d = wstrb_q;
        result_d = result_q; fault_d = fault_q; cause_d = cause_q; cnt_d = cnt_q;
        case (state_q)
            IDLE: if (bus.enabled) begin
                load_d = is_load; uns_d = bus.op_unsigned; size_d = bus.op_size; off_d = off_in;
                cnt_d  = '0;
                if (!(is_load | is_store)) begin
                    result_d = '0; fault_d = 1'b0; cause_d = 2'd0;
                end else if (misaligned) begin
                    result_d = '0; fault_d = 1'b1; cause_d = is_load ? 2'd1 : 2'd2;
                end else begin
                    req_d   = 1'b1;
                    mode_d  = is_store ? MEMREQ_WRITE : MEMREQ_READ;
                    addr_d  = {bus.op_addr[ADDR_W-1:LB], {LB{1'b0}}};
                    wstrb_d = is_store ? (NB'(lane8) << off_in) : '0;
                    wdata_d = bus.op_wdata << {off_in, 3'b000};
                end
            end
            // A response in the timeout cycle is checked first so it wins.
            WAIT: if (bus.response_enable) begin
                result_d = load_q ? ext : '0; fault_d = 1'b0; cause_d = 2'd0;
            end else if (timeout_hit) begin
                result_d = '0; fault_d = 1'b1; cause_d = 2'd3;
            end else if (TIMEOUT != 0) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q <= 1'b0; uns_q <= 1'b0; size_q <= 2'd0; off_q <= '0;
            req_q <= 1'b0; mode_q <= MEMREQ_READ; addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
            result_q <= '0; fault_q <= 1'b0; cause_q <= 2'd0; cnt_q <= '0;
        end else begin
            load_q <= load_d; uns_q <= uns_d; size_q <= size_d; off_q <= off_d;
            req_q <= req_d; mode_q <= mode_d; addr_q <= addr_d; wdata_q <= wdata_d; wstrb_q <= wstrb_d;
            result_q <= result_d; fault_q <= fault_d; cause_q <= cause_d; cnt_q <= cnt_d;
        end
    end

    always_comb begin
        bus.completed      = (state_q == RESP);
        bus.request_enable = req_q;
        bus.mode           = mode_q;
        bus.addr           = addr_q;
        bus.wdata          = wdata_q;
        bus.wstrb          = wstrb_q;
        bus.result         = result_q;
        bus.fault          = fault_q;
        bus.fault_cause    = cause_q;
        dbg_state_o        = state_q;
    end
endmodule
